// File: rtl/serial_paralelo_rx_if.sv
// serial_paralelo_rx_if: serial lane in, aligned byte stream out
//   data_in      1  serial bit, MSB of each byte first (driven by master)
//   data_out     8  last received non-comma byte
//   valid_out    1  data_out carries a data byte for the current byte period
//   byte_strobe  1  one-cycle pulse per completed aligned byte
//   active       1  link aligned and trained
interface serial_paralelo_rx_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;
    modport master (output data_in, input data_out, valid_out, byte_strobe, active);
    modport slave  (input data_in, output data_out, valid_out, byte_strobe, active);
endinterface

// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: deserialises the 1-bit lane, aligns on comma, delivers bytes
//   clk_32f  bit clock, rising edge
//   reset    asynchronous, active-low
//   bus      serial_paralelo_rx_if.slave (data_in in; data_out/valid_out/byte_strobe/active out)
module serial_paralelo_rx #(
    parameter logic [7:0] COMMA        = 8'hBC,
    parameter int         BC_THRESHOLD = 4
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    serial_paralelo_rx_if.slave  bus
);
    typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;
    state_t     r_state;
    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_comma_cnt;
    logic [7:0] r_data_out;
    logic       r_valid_out;
    logic       r_byte_strobe;
    logic       r_active;
    logic [7:0] w_sr_next;
    logic       w_boundary;
    logic       w_comma;
    assign w_sr_next  = {r_sr[6:0], bus.data_in};
    assign w_boundary = r_bit_cnt == 3'd7;
    assign w_comma    = w_sr_next == COMMA;
    assign bus.data_out    = r_data_out;
    assign bus.valid_out   = r_valid_out;
    assign bus.byte_strobe = r_byte_strobe;
    assign bus.active      = r_active;
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state       <= SEARCH;
            r_sr          <= 8'd0;
            r_bit_cnt     <= 3'd0;
            r_comma_cnt   <= 4'd0;
            r_data_out    <= 8'd0;
            r_valid_out   <= 1'b0;
            r_byte_strobe <= 1'b0;
            r_active      <= 1'b0;
        end else begin
            r_sr          <= w_sr_next;
            r_bit_cnt     <= r_bit_cnt + 3'd1;
            r_byte_strobe <= 1'b0;
            case (r_state)
                // unaligned hunt: a comma at any bit offset fixes the byte phase
                SEARCH: if (w_comma) begin
                    r_state     <= ALIGN;
                    r_comma_cnt <= 4'd1;
                    r_bit_cnt   <= 3'd0;
                end
                ALIGN: if (w_boundary) begin
                    if (!w_comma) begin
                        r_state     <= SEARCH;
                        r_comma_cnt <= 4'd0;
                    end else begin
                        r_comma_cnt <= r_comma_cnt + 4'd1;
                        if (r_comma_cnt + 4'd1 == 4'(BC_THRESHOLD)) begin
                            r_state  <= ACTIVE;
                            r_active <= 1'b1;
                        end
                    end
                end
                // idle commas mark the byte period invalid but keep the last data byte
                ACTIVE: if (w_boundary) begin
                    r_byte_strobe <= 1'b1;
                    r_valid_out   <= !w_comma;
                    if (!w_comma) r_data_out <= w_sr_next;
                end
                default: r_state <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx: directed scoreboard bench for serial_paralelo_rx
module tb_serial_paralelo_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic       exp_act = 1'b0;
    logic [7:0] last = 8'd0;
    logic [8:0] sb[$];
    logic [8:0] e;
    serial_paralelo_rx_if bus ();
    serial_paralelo_rx dut (.clk_32f(clk), .reset(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic send_bit(input logic b);
        bus.data_in = b;
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic send_byte(input logic [7:0] b);
        if (exp_act) begin
            sb.push_back(b == 8'hBC ? {1'b0, last} : {1'b1, b});
            if (b != 8'hBC) last = b;
        end
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (exp_act) begin
                chk("strobe", {8'd0, bus.byte_strobe}, {8'd0, i == 0});
                if (i == 0) begin
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("valid_data", {bus.valid_out, bus.data_out}, e);
                    end else chk("scoreboard_empty", 9'd1, 9'd0);
                end
            end
        end
    endtask
    task automatic chk_all_zero(input string tag);
        chk(tag, {bus.active, bus.valid_out, bus.byte_strobe, bus.data_out[5:0]}, 9'd0);
        chk(tag, {1'b0, bus.data_out}, 9'd0);
    endtask
    task automatic do_reset();
        exp_act = 1'b0;
        last = 8'd0;
        sb.delete();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        bus.data_in = 1'b0;
        // 1: reset held, data toggling
        for (int i = 0; i < 12; i++) begin
            bus.data_in = i[0];
            @(negedge clk);
        end
        chk_all_zero("in_reset");
        rst_n = 1'b1;
        send_byte(8'hBC);
        chk("search_after_release", {8'd0, bus.active}, 9'd0);
        do_reset();
        // 2: 1,0,1 then 4 commas
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        chk("active_before_threshold", {8'd0, bus.active}, 9'd0);
        send_byte(8'hBC);
        chk("active_after_35", {8'd0, bus.active}, 9'd1);
        chk("valid_at_activation", {8'd0, bus.valid_out}, 9'd0);
        chk("no_strobe_at_activation", {8'd0, bus.byte_strobe}, 9'd0);
        exp_act = 1'b1;
        // 3: data bytes
        send_byte(8'hFF);
        send_byte(8'hEE);
        // 5: comma in ACTIVE holds data, drops valid
        send_byte(8'h12);
        send_byte(8'hBC);
        send_byte(8'h34);
        chk("active_held", {8'd0, bus.active}, 9'd1);
        // 4: interrupted training
        do_reset();
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        chk("active_3_commas", {8'd0, bus.active}, 9'd0);
        send_byte(8'h55);
        chk("active_after_55", {8'd0, bus.active}, 9'd0);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        chk("active_retrain_3", {8'd0, bus.active}, 9'd0);
        send_byte(8'hBC);
        chk("active_retrain_4", {8'd0, bus.active}, 9'd1);
        exp_act = 1'b1;
        send_byte(8'h5A);
        send_byte(8'hBC);
        // 6: async reset mid-byte
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        exp_act = 1'b0;
        last = 8'd0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h55);
        send_byte(8'hA5);
        chk("no_active_without_commas", {8'd0, bus.active}, 9'd0);
        chk("no_valid_without_commas", {8'd0, bus.valid_out}, 9'd0);
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        chk("active_after_reset_train", {8'd0, bus.active}, 9'd1);
        exp_act = 1'b1;
        send_byte(8'hC3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
